// File: rtl/gray_to_bin_tracker.sv
// Gray-to-binary decoder with step tracking.
// Each captured Gray sample is decoded and registered, then classified
// against the previous position as hold, +1, -1 or an illegal jump.
// Illegal jumps are tallied in a saturating counter.
module gray_to_bin_tracker #(
   parameter int WIDTH = 4,
   parameter int ERRW  = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_g,
   input  logic             i_g_valid,
   input  logic             i_clear,
   output logic [WIDTH-1:0] o_b,
   output logic             o_b_valid,
   output logic             o_step_up,
   output logic             o_step_dn,
   output logic             o_err,
   output logic [ERRW-1:0]  o_err_cnt,
   output logic             o_locked
);

   typedef enum logic {
      S_INIT  = 1'b0,
      S_TRACK = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] DELTA_UP = WIDTH'(1);
   localparam logic [WIDTH-1:0] DELTA_DN = '1;
   localparam logic [ERRW-1:0]  CNT_MAX  = '1;
   localparam logic [ERRW-1:0]  CNT_ONE  = ERRW'(1);

   state_t           r_state;
   state_t           w_state_next;
   // The registered output b is always the last decoded position, so it
   // also serves as the reference value b_prev for the next comparison.
   logic [WIDTH-1:0] r_b;
   logic             r_b_valid;
   logic             r_step_up;
   logic             r_step_dn;
   logic             r_err;
   logic [ERRW-1:0]  r_err_cnt;
   logic             r_locked;

   logic [WIDTH-1:0] w_dec;
   logic [WIDTH-1:0] w_delta;
   logic             w_step_up;
   logic             w_step_dn;
   logic             w_err;

   // Gray decode: each binary bit is the XOR of all Gray bits at and above it.
   always_comb begin
      w_dec = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_dec[i] = ^(i_g >> i);
      end
   end

   assign w_delta = w_dec - r_b;

   // Next state and step classification; a sample taken with clear or in
   // INIT only establishes the reference and never reports a step or error.
   always_comb begin
      w_state_next = r_state;
      w_step_up    = 1'b0;
      w_step_dn    = 1'b0;
      w_err        = 1'b0;
      if (i_g_valid) begin
         w_state_next = S_TRACK;
         if (!i_clear && (r_state == S_TRACK)) begin
            if (w_delta == DELTA_UP) begin
               w_step_up = 1'b1;
            end else if (w_delta == DELTA_DN) begin
               w_step_dn = 1'b1;
            end else if (w_delta != '0) begin
               w_err = 1'b1;
            end
         end
      end else if (i_clear) begin
         w_state_next = S_INIT;
      end
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_INIT;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Position register and one-cycle result pulses.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_b       <= '0;
         r_b_valid <= 1'b0;
         r_step_up <= 1'b0;
         r_step_dn <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         if (i_g_valid) begin
            r_b <= w_dec;
         end
         r_b_valid <= i_g_valid;
         r_step_up <= w_step_up;
         r_step_dn <= w_step_dn;
         r_err     <= w_err;
      end
   end

   // Saturating illegal-jump counter; clear takes priority.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_err_cnt <= '0;
      end else if (i_clear) begin
         r_err_cnt <= '0;
      end else if (w_err && (r_err_cnt != CNT_MAX)) begin
         r_err_cnt <= r_err_cnt + CNT_ONE;
      end
   end

   // Lock flag follows TRACK, but is held low for the cycle after a clear so
   // that a clear is visible even when a sample re-establishes the reference.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_locked <= 1'b0;
      end else begin
         r_locked <= (w_state_next == S_TRACK) && !i_clear;
      end
   end

   assign o_b       = r_b;
   assign o_b_valid = r_b_valid;
   assign o_step_up = r_step_up;
   assign o_step_dn = r_step_dn;
   assign o_err     = r_err;
   assign o_err_cnt = r_err_cnt;
   assign o_locked  = r_locked;

endmodule

// File: tb/tb_gray_to_bin_tracker.sv
// Self-checking bench for gray_to_bin_tracker (WIDTH=4, ERRW=2).
// A position-level reference model predicts every output after each edge.
module tb_gray_to_bin_tracker;

   localparam int WIDTH = 4;
   localparam int ERRW  = 2;
   localparam int POS_N = 1 << WIDTH;
   localparam int CNT_SAT = (1 << ERRW) - 1;

   logic             clk;
   logic             rstN;
   logic [WIDTH-1:0] g;
   logic             gValid;
   logic             clear;
   logic [WIDTH-1:0] b;
   logic             bValid;
   logic             stepUp;
   logic             stepDn;
   logic             err;
   logic [ERRW-1:0]  errCnt;
   logic             locked;

   int nVectors;
   int nMiscompares;

   // Reference model state: whether a reference position exists, the last
   // position, the error tally and the expected outputs after the next edge.
   bit haveRef;
   int prevPos;
   int modelCnt;
   int expB;
   bit expValid;
   bit expUp;
   bit expDn;
   bit expErr;
   bit expLocked;

   gray_to_bin_tracker #(
      .WIDTH(WIDTH),
      .ERRW (ERRW)
   ) dut (
      .i_clk    (clk),
      .i_rst_n  (rstN),
      .i_g      (g),
      .i_g_valid(gValid),
      .i_clear  (clear),
      .o_b      (b),
      .o_b_valid(bValid),
      .o_step_up(stepUp),
      .o_step_dn(stepDn),
      .o_err    (err),
      .o_err_cnt(errCnt),
      .o_locked (locked)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int toGray(input int n);
      return n ^ (n >> 1);
   endfunction

   // Decode by searching for the position whose Gray code matches.
   function automatic int grayDecode(input int gv);
      for (int n = 0; n < POS_N; n++) begin
         if (toGray(n) == gv) return n;
      end
      return -1;
   endfunction

   task automatic checkOne(input string tag, input int observed, input int expected);
      nVectors++;
      assert (observed === expected)
      else begin
         nMiscompares++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkOne({tag, ".b"},       int'(b),      expB);
      checkOne({tag, ".b_valid"}, int'(bValid), int'(expValid));
      checkOne({tag, ".step_up"}, int'(stepUp), int'(expUp));
      checkOne({tag, ".step_dn"}, int'(stepDn), int'(expDn));
      checkOne({tag, ".err"},     int'(err),    int'(expErr));
      checkOne({tag, ".err_cnt"}, int'(errCnt), modelCnt);
      checkOne({tag, ".locked"},  int'(locked), int'(expLocked));
   endtask

   // Apply one cycle of inputs, advance the model, then check after the edge.
   task automatic applyStimulus(input int gv, input bit v, input bit c, input string tag);
      int pos;
      int d;
      @(negedge clk);
      g      = WIDTH'(gv);
      gValid = v;
      clear  = c;
      expUp  = 0;
      expDn  = 0;
      expErr = 0;
      expValid = v;
      if (v) begin
         pos = grayDecode(gv);
         if (haveRef && !c) begin
            d = (pos - prevPos + POS_N) % POS_N;
            if (d == 1) expUp = 1;
            else if (d == POS_N - 1) expDn = 1;
            else if (d != 0) begin
               expErr = 1;
               if (modelCnt < CNT_SAT) modelCnt++;
            end
         end
         prevPos = pos;
         expB    = pos;
         haveRef = 1;
      end
      if (c) begin
         modelCnt = 0;
         if (!v) haveRef = 0;
      end
      expLocked = haveRef && !c;
      @(posedge clk);
      #1;
      checkOutput(tag);
      gValid = 1'b0;
      clear  = 1'b0;
   endtask

   task automatic resetModel();
      haveRef   = 0;
      prevPos   = 0;
      modelCnt  = 0;
      expB      = 0;
      expValid  = 0;
      expUp     = 0;
      expDn     = 0;
      expErr    = 0;
      expLocked = 0;
   endtask

   initial begin
      int pick;
      int gv;
      nVectors     = 0;
      nMiscompares = 0;
      rstN   = 1'b0;
      g      = '0;
      gValid = 1'b0;
      clear  = 1'b0;
      resetModel();

      // Reset state while reset is held.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset");
      @(negedge clk);
      rstN = 1'b1;

      // Decode sweep: Gray(0..15) counts up with a step on all but the first.
      for (int n = 0; n < POS_N; n++) applyStimulus(toGray(n), 1, 0, "sweep");

      // Wrap-around both ways.
      applyStimulus(4'b1000, 1, 0, "wrap_hold15");
      applyStimulus(4'b0000, 1, 0, "wrap_up_to0");
      applyStimulus(4'b1000, 1, 0, "wrap_dn_to15");
      applyStimulus(4'b1001, 1, 0, "wrap_dn_to14");

      // Illegal jump then resynchronised step.
      applyStimulus(4'b0000, 1, 0, "jump_base");
      applyStimulus(4'b0110, 1, 0, "jump_illegal");
      applyStimulus(4'b0111, 1, 0, "jump_resync");

      // Hold with idle gaps: clear first so the repeats start fresh.
      applyStimulus(0, 0, 1, "hold_clear");
      for (int k = 0; k < 4; k++) begin
         applyStimulus(4'b0011, 1, 0, "hold_sample");
         applyStimulus(4'b0101, 0, 0, "hold_idle");
         applyStimulus(4'b0000, 0, 0, "hold_idle2");
      end

      // Saturation: five illegal jumps between positions 0 and 8.
      applyStimulus(toGray(0), 1, 0, "sat_base");
      for (int k = 0; k < 5; k++) begin
         applyStimulus(toGray((k % 2 == 0) ? 8 : 0), 1, 0, "sat_jump");
      end

      // Clear together with an otherwise illegal sample, then a legal step.
      applyStimulus(toGray(4), 1, 1, "clear_with_sample");
      applyStimulus(toGray(5), 1, 0, "after_clear_step");
      applyStimulus(toGray(5), 0, 0, "after_clear_idle");

      // Randomised stream biased toward legal moves.
      for (int k = 0; k < 400; k++) begin
         pick = $urandom_range(0, 9);
         if (pick < 3) gv = toGray((prevPos + 1) % POS_N);
         else if (pick < 5) gv = toGray((prevPos + POS_N - 1) % POS_N);
         else if (pick < 6) gv = toGray(prevPos);
         else gv = $urandom_range(0, POS_N - 1);
         applyStimulus(gv, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), "random");
      end

      // Asynchronous reset between edges during a stepping sequence.
      applyStimulus(toGray(6), 1, 0, "mid_base");
      applyStimulus(toGray(7), 1, 0, "mid_step");
      #2;
      rstN = 1'b0;
      #1;
      resetModel();
      checkOutput("mid_reset");
      @(negedge clk);
      rstN = 1'b1;
      applyStimulus(toGray(1), 1, 0, "post_reset_init");
      applyStimulus(toGray(2), 1, 0, "post_reset_step");

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule

// File: doc/gray_to_bin_tracker.md
# gray_to_bin_tracker

Registered Gray-to-binary decoder with step tracking. It accepts a stream of Gray-coded samples, such as a position sensor or a Gray-coded counter crossing into this clock domain, and converts each sample to binary. Each sample is classified against the previous one as hold, +1, −1, or illegal, and illegal transitions are counted. It is the receiving end of the binary-to-Gray encoder path and sits downstream of any Gray-coded source in the design.

## Interface
- WIDTH, 4, width of Gray input and binary output (2..16)
- ERRW, 8, width of saturating error counter

- clk  in  1  rising-edge clock, single domain
- rst_n  in  1  asynchronous active-low reset
- g  in  WIDTH  Gray-coded sample, already synchronous to clk
- g_valid  in  1  sample qualifier; g is captured on a clk edge where g_valid=1
- clear  in  1  synchronous: zero err_cnt, return to INIT
- b  out  WIDTH  registered binary decode of last captured g
- b_valid  out  1  one-cycle pulse, b/step/err updated this cycle
- step_up  out  1  pulse with b_valid: b = b_prev + 1 (mod 2^WIDTH)
- step_dn  out  1  pulse with b_valid: b = b_prev − 1 (mod 2^WIDTH)
- err  out  1  pulse with b_valid: decoded delta is not 0 or ±1
- err_cnt  out  ERRW  saturating count of err pulses
- locked  out  1  high in TRACK state

## Operation
- Decode: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i] for i from WIDTH-2 down to 0. The decode is purely combinational on the captured sample and is registered into b.
- State machine has two states:
  - INIT: no reference value. A captured sample loads b and b_prev and asserts b_valid. step_up, step_dn and err stay 0. Next state is TRACK.
  - TRACK: delta = decode(g) − b_prev, modulo 2^WIDTH.
    - delta=0: b_valid only (hold).
    - delta=1: step_up.
    - delta=2^WIDTH−1: step_dn.
    - Any other delta: err, and err_cnt increments.
    - In every case b and b_prev load the new value, so tracking resynchronises to the new position.
- Wrap-around is legal:
  - b_prev=2^WIDTH−1 to b=0 is step_up.
  - b_prev=0 to b=2^WIDTH−1 is step_dn.
- err_cnt saturates at 2^ERRW−1 and never wraps.
- clear behaviour:
  - Next state is INIT and err_cnt becomes 0.
  - A sample captured in the same cycle as clear is still decoded and drives b/b_valid, but is treated as an INIT sample: no step, no err, no count.
  - The FSM is then in TRACK with the new b_prev.
- g_valid=0: all registers hold and all pulses are 0.

## Timing
- Latency is 1 cycle. A sample captured at edge N produces b, b_valid and step/err valid after edge N, for exactly one cycle. b itself holds until the next capture.
- Back-to-back g_valid on every cycle is supported, at one result per cycle. There is no backpressure.
- step_up, step_dn and err are mutually exclusive and are only ever high together with b_valid.
- Reset values (rst_n=0, asynchronous):
  - b=0, b_prev=0, b_valid=0, step_up=0, step_dn=0, err=0, err_cnt=0, locked=0.
  - State is INIT.
- Reset deassertion is synchronised by the system. The first capture after reset is an INIT sample.
- Reset mid-stream: outputs clear immediately and any in-flight pulse is dropped.

## Test plan
- Decode sweep, WIDTH=4, g = Gray(0..15) in sequence: b = 0..15. The first result has no step; the next 15 each pulse step_up. err_cnt stays 0.
- Wrap and reverse: g=1000 (b=15), then 0000 gives step_up with b=0; then 1000 again gives step_dn with b=15; then 1001 gives step_dn with b=14.
- Illegal jump: from g=0000 apply g=0110. Required: b=0100, err=1, err_cnt=1, and locked stays 1. Then g=0111 gives b=0101 with step_up, showing the block resynchronises.
- Hold and gaps: repeat g=0011 (b=2) with idle cycles between samples. Required: b_valid pulses with no step or err, and there are no pulses on idle cycles.
- Saturation and clear, with ERRW=2:
  - Drive 5 illegal jumps: err_cnt reads 1, 2, 3, 3, 3.
  - Assert clear together with a sample: err_cnt=0, locked drops for one cycle, and there is no err on that sample.
- Async reset mid-stream: assert rst_n=0 between edges during a stepping sequence. All outputs read 0 before the next edge. The first sample after release is an INIT sample.
